daa_mac_accumulator: RTL and testbench

Downstream consumer of the 8x8 multiplier's 16-bit product stream. Sums a fixed-length frame of LEN products into a wider accumulator (dot-product / MAC stage) and presents each frame sum on a registered valid/ready output. Products enter through a valid/ready handshake so the multiplier stage can be back-pressured while a completed sum waits to be taken.

---
 rtl/daa_mac_accumulator_if.sv | 39 +++
 rtl/daa_mac_accumulator.sv | 117 +++++++++++
 tb/tb_daa_mac_accumulator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/daa_mac_accumulator_if.sv
//-----------------------------------------------------------------------------
// daa_mac_accumulator_if
// Groups the product-input and result-output handshakes of the MAC
// accumulator so that they can be passed as one port.
//   prod_in/prod_valid/prod_ready : product stream from the multiplier
//   clear                         : synchronous abort of the partial frame
//   acc_out/acc_ovf/acc_valid/acc_ready : registered frame result
//   beat_cnt                      : products accepted in the current frame
// Modports:
//   master : environment side (drives products, consumes results)
//   slave  : accumulator side
//-----------------------------------------------------------------------------
interface daa_mac_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 8
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_ready;
    logic              clear;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_ovf;
    logic              acc_valid;
    logic              acc_ready;
    logic [CNT_W-1:0]  beat_cnt;

    modport master (
        output prod_in, prod_valid, clear, acc_ready,
        input  prod_ready, acc_out, acc_ovf, acc_valid, beat_cnt
    );

    modport slave (
        input  prod_in, prod_valid, clear, acc_ready,
        output prod_ready, acc_out, acc_ovf, acc_valid, beat_cnt
    );
endinterface

// File: rtl/daa_mac_accumulator.sv
//-----------------------------------------------------------------------------
// daa_mac_accumulator
// Sums frames of LEN unsigned products into an ACC_W-bit accumulator and
// presents each frame sum on a registered valid/ready output.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : daa_mac_accumulator_if.slave (product input, clear, result output)
// Build option:
//   MAC_SATURATE_EN : when defined, the running sum clamps to all ones on
//                     overflow and stays there for the rest of the frame.
//                     When undefined, arithmetic wraps modulo 2^ACC_W.
//                     acc_ovf flags the event in both builds.
//-----------------------------------------------------------------------------
module daa_mac_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    daa_mac_accumulator_if.slave    bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LEN - 1);

    logic [ACC_W-1:0] acc_q,      acc_d;
    logic             ovf_run_q,  ovf_run_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ACC_W-1:0] acc_out_q,  acc_out_d;
    logic             acc_ovf_q,  acc_ovf_d;
    logic             acc_valid_q, acc_valid_d;

    logic             last_beat;
    logic             prod_ready;
    logic             accept;
    logic             take;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] sum_val;

    assign last_beat = (beat_cnt_q == LAST_BEAT);
    // Only the last beat has to wait, and only if the held result is not
    // leaving this cycle; this is the sole combinational input->output path.
    assign prod_ready = !(acc_valid_q && last_beat && !bus.acc_ready);
    assign accept     = bus.prod_valid && prod_ready;
    assign take       = acc_valid_q && bus.acc_ready;

    // One extra bit captures the carry out of the accumulator MSB.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_in};
    assign carry   = sum_ext[ACC_W];

`ifdef MAC_SATURATE_EN
    // Once clamped at all ones any non-zero product carries again, so the
    // clamp persists until the frame ends.
    assign sum_val = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign sum_val = sum_ext[ACC_W-1:0];
`endif

    always_comb begin
        acc_d       = acc_q;
        ovf_run_d   = ovf_run_q;
        beat_cnt_d  = beat_cnt_q;
        acc_out_d   = acc_out_q;
        acc_ovf_d   = acc_ovf_q;
        acc_valid_d = acc_valid_q;

        if (take) begin
            acc_valid_d = 1'b0;
        end

        if (bus.clear) begin
            // The handshake still completes, but the product is dropped.
            acc_d      = '0;
            ovf_run_d  = 1'b0;
            beat_cnt_d = '0;
        end else if (accept) begin
            if (last_beat) begin
                acc_out_d   = sum_val;
                acc_ovf_d   = ovf_run_q | carry;
                acc_valid_d = 1'b1;
                acc_d       = '0;
                ovf_run_d   = 1'b0;
                beat_cnt_d  = '0;
            end else begin
                acc_d      = sum_val;
                ovf_run_d  = ovf_run_q | carry;
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            ovf_run_q   <= 1'b0;
            beat_cnt_q  <= '0;
            acc_out_q   <= '0;
            acc_ovf_q   <= 1'b0;
            acc_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_run_q   <= ovf_run_d;
            beat_cnt_q  <= beat_cnt_d;
            acc_out_q   <= acc_out_d;
            acc_ovf_q   <= acc_ovf_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.acc_out    = acc_out_q;
    assign bus.acc_ovf    = acc_ovf_q;
    assign bus.acc_valid  = acc_valid_q;
    assign bus.beat_cnt   = beat_cnt_q;
endmodule

// File: tb/tb_daa_mac_accumulator.sv
module tb_daa_mac_accumulator;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic done;

    daa_mac_accumulator_if #(.PROD_W(16), .ACC_W(24), .LEN(4)) bus_a ();
    daa_mac_accumulator_if #(.PROD_W(16), .ACC_W(17), .LEN(4)) bus_b ();

    daa_mac_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(4)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    daa_mac_accumulator #(.PROD_W(16), .ACC_W(17), .LEN(4)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            $display("PASS %s value=%0d", tag, obs);
        end
    endtask

    initial begin
        done = 1'b0;
        #20000;
        if (!done) begin
            $error("FAIL watchdog: stimulus did not complete within 20000 time units");
            $finish;
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        bus_a.prod_in = '0; bus_a.prod_valid = 1'b0; bus_a.clear = 1'b0; bus_a.acc_ready = 1'b1;
        bus_b.prod_in = '0; bus_b.prod_valid = 1'b0; bus_b.clear = 1'b0; bus_b.acc_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        n_vec++;
        if (bus_a.acc_out !== 24'd0 || bus_a.acc_ovf !== 1'b0 || bus_a.acc_valid !== 1'b0 ||
            bus_a.beat_cnt !== 2'd0 || bus_a.prod_ready !== 1'b1 ||
            bus_b.acc_out !== 17'd0 || bus_b.acc_valid !== 1'b0) begin
            n_err++;
            $error("FAIL rst_state acc_out=%0d acc_ovf=%0d acc_valid=%0d beat_cnt=%0d prod_ready=%0d",
                   bus_a.acc_out, bus_a.acc_ovf, bus_a.acc_valid, bus_a.beat_cnt, bus_a.prod_ready);
        end else begin
            $display("PASS rst_state");
        end
        chk("rst_acc_out",    bus_a.acc_out,    24'd0);
        chk("rst_acc_ovf",    bus_a.acc_ovf,    1'b0);
        chk("rst_acc_valid",  bus_a.acc_valid,  1'b0);
        chk("rst_beat_cnt",   bus_a.beat_cnt,   2'd0);
        chk("rst_prod_ready", bus_a.prod_ready, 1'b1);

        bus_a.prod_valid = 1'b1;
        bus_a.prod_in = 16'd100; tick();
        bus_a.prod_in = 16'd200; tick();
        bus_a.prod_in = 16'd300; tick();
        chk("f1_beat_cnt_3",  bus_a.beat_cnt,  2'd3);
        chk("f1_no_valid_early", bus_a.acc_valid, 1'b0);
        bus_a.prod_in = 16'd400; tick();
        bus_a.prod_valid = 1'b0;
        chk("f1_acc_valid",   bus_a.acc_valid, 1'b1);
        chk("f1_acc_out",     bus_a.acc_out,   24'd1000);
        chk("f1_acc_ovf",     bus_a.acc_ovf,   1'b0);
        chk("f1_beat_cnt_0",  bus_a.beat_cnt,  2'd0);
        tick();
        chk("f1_valid_one_cycle", bus_a.acc_valid, 1'b0);
        chk("f1_out_held",    bus_a.acc_out,   24'd1000);

        bus_b.prod_valid = 1'b1;
        bus_b.prod_in = 16'd65025;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bus_b.beat_cnt !== i[1:0]) begin
                n_err++;
                $error("FAIL ovf_beat_cnt observed=%0d expected=%0d", bus_b.beat_cnt, i);
            end else begin
                $display("PASS ovf_beat_cnt value=%0d", bus_b.beat_cnt);
            end
            tick();
        end
        bus_b.prod_valid = 1'b0;
        chk("ovf_acc_valid",  bus_b.acc_valid, 1'b1);
`ifdef MAC_SATURATE_EN
        chk("ovf_acc_out",    bus_b.acc_out,   17'd131071);
`else
        chk("ovf_acc_out",    bus_b.acc_out,   17'd129028);
`endif
        chk("ovf_acc_ovf",    bus_b.acc_ovf,   1'b1);
        tick();

        bus_a.acc_ready = 1'b0;
        bus_a.prod_valid = 1'b1;
        bus_a.prod_in = 16'd1;
        tick(); tick(); tick(); tick();
        chk("bp_f1_valid",    bus_a.acc_valid, 1'b1);
        chk("bp_f1_out",      bus_a.acc_out,   24'd4);
        chk("bp_ready_beat0", bus_a.prod_ready, 1'b1);
        tick(); tick(); tick();
        chk("bp_beat_cnt_3",  bus_a.beat_cnt,  2'd3);
        chk("bp_ready_low",   bus_a.prod_ready, 1'b0);
        tick();
        chk("bp_stall_cnt",   bus_a.beat_cnt,  2'd3);
        chk("bp_stall_out",   bus_a.acc_out,   24'd4);
        chk("bp_stall_valid", bus_a.acc_valid, 1'b1);
        bus_a.acc_ready = 1'b1;
        #1;
        chk("bp_ready_comb",  bus_a.prod_ready, 1'b1);
        tick();
        bus_a.prod_valid = 1'b0;
        chk("bp_f2_valid",    bus_a.acc_valid, 1'b1);
        chk("bp_f2_out",      bus_a.acc_out,   24'd4);
        chk("bp_f2_cnt",      bus_a.beat_cnt,  2'd0);
        tick();
        chk("bp_f2_taken",    bus_a.acc_valid, 1'b0);

        bus_a.prod_valid = 1'b1;
        bus_a.prod_in = 16'd7;
        tick(); tick();
        chk("clr_cnt_before", bus_a.beat_cnt,  2'd2);
        bus_a.clear = 1'b1;
        bus_a.prod_in = 16'd9;
        #1;
        chk("clr_ready",      bus_a.prod_ready, 1'b1);
        tick();
        bus_a.clear = 1'b0;
        chk("clr_cnt_after",  bus_a.beat_cnt,  2'd0);
        chk("clr_out_held",   bus_a.acc_out,   24'd4);
        chk("clr_no_valid",   bus_a.acc_valid, 1'b0);
        bus_a.acc_ready = 1'b0;
        bus_a.prod_in = 16'd5;
        tick(); tick(); tick(); tick();
        chk("clr_next_valid", bus_a.acc_valid, 1'b1);
        chk("clr_next_out",   bus_a.acc_out,   24'd20);

        bus_a.prod_in = 16'd3;
        tick(); tick();
        chk("ar_cnt_before",  bus_a.beat_cnt,  2'd2);
        bus_a.prod_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_acc_out",     bus_a.acc_out,   24'd0);
        chk("ar_acc_valid",   bus_a.acc_valid, 1'b0);
        chk("ar_beat_cnt",    bus_a.beat_cnt,  2'd0);
        chk("ar_acc_ovf_b",   bus_b.acc_ovf,   1'b0);
        tick();
        reset = 1'b0;
        bus_a.acc_ready = 1'b1;
        #1;
        chk("ar_prod_ready",  bus_a.prod_ready, 1'b1);
        bus_a.prod_valid = 1'b1;
        bus_a.prod_in = 16'd1; tick();
        bus_a.prod_in = 16'd2; tick();
        bus_a.prod_in = 16'd3; tick();
        bus_a.prod_in = 16'd4; tick();
        bus_a.prod_valid = 1'b0;
        chk("ar_next_valid",  bus_a.acc_valid, 1'b1);
        chk("ar_next_out",    bus_a.acc_out,   24'd10);
        chk("ar_next_ovf",    bus_a.acc_ovf,   1'b0);
        tick();

        done = 1'b1;
        if (n_err != 0) begin
            $error("FAIL summary: %0d miscompares out of %0d vectors", n_err, n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
